// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives a request/ack instruction memory, buffers one
// early return in a skid entry and handles redirects, flushing in-flight reads.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = 16'h0000
) (
    input  logic        inp_clk,
    input  logic        inp_rst_n,
    input  logic        pcSrc,
    input  logic [15:0] branchTarget_address,
    input  logic        stall,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic [15:0] pc_address
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic        mem_req_r, mem_req_s;
    logic [15:0] mem_addr_r, mem_addr_s;
    logic [15:0] instr_r, instr_s;
    logic        valid_r, valid_s;
    logic [15:0] pa_r, pa_s;
    logic        skid_valid_r, skid_valid_s;
    logic [15:0] skid_data_r, skid_data_s;
    logic [15:0] skid_addr_r, skid_addr_s;
    logic        ack_s;
    logic        consume_s;

    assign mem_req     = mem_req_r;
    assign mem_addr    = mem_addr_r;
    assign instruction = instr_r;
    assign instr_valid = valid_r;
    assign pc_address  = pa_r;

    // Next-state, request and output-stage computation.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        mem_req_s    = mem_req_r;
        mem_addr_s   = mem_addr_r;
        instr_s      = instr_r;
        valid_s      = valid_r;
        pa_s         = pa_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        skid_addr_s  = skid_addr_r;
        ack_s        = mem_req_r & mem_ack;
        consume_s    = valid_r & ~stall;

        case (state_r)
            S_IDLE: begin
                state_s    = S_FETCH;
                mem_req_s  = 1'b1;
                mem_addr_s = pc_r;
            end
            S_FETCH: begin
                if (pcSrc) begin
                    valid_s      = 1'b0;
                    instr_s      = NOP;
                    skid_valid_s = 1'b0;
                    pc_s         = branchTarget_address;
                    // An unacknowledged request cannot be withdrawn; drain it first.
                    if (mem_req_r && !mem_ack) begin
                        state_s = S_FLUSH;
                    end else begin
                        mem_req_s  = 1'b1;
                        mem_addr_s = branchTarget_address;
                    end
                end else if (ack_s) begin
                    if (!valid_r || consume_s) begin
                        instr_s = mem_rdata;
                        pa_s    = mem_addr_r;
                        valid_s = 1'b1;
                    end else begin
                        skid_valid_s = 1'b1;
                        skid_data_s  = mem_rdata;
                        skid_addr_s  = mem_addr_r;
                    end
                    pc_s       = pc_r + 16'd1;
                    mem_addr_s = pc_r + 16'd1;
                    mem_req_s  = ~(valid_r & ~consume_s);
                end else begin
                    if (consume_s) begin
                        if (skid_valid_r) begin
                            instr_s      = skid_data_r;
                            pa_s         = skid_addr_r;
                            valid_s      = 1'b1;
                            skid_valid_s = 1'b0;
                        end else begin
                            instr_s = NOP;
                            valid_s = 1'b0;
                        end
                    end else begin
                        valid_s = valid_r;
                    end
                    if (!mem_req_r) begin
                        mem_req_s  = ~skid_valid_r | consume_s;
                        mem_addr_s = pc_r;
                    end else begin
                        mem_req_s = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                // pc holds the latest redirect target while the stale read drains.
                valid_s = 1'b0;
                instr_s = NOP;
                if (pcSrc) begin
                    pc_s = branchTarget_address;
                end else begin
                    pc_s = pc_r;
                end
                if (ack_s) begin
                    state_s    = S_FETCH;
                    mem_req_s  = 1'b1;
                    mem_addr_s = pcSrc ? branchTarget_address : pc_r;
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            default: begin
                state_s      = S_IDLE;
                pc_s         = RESET_PC;
                mem_req_s    = 1'b0;
                mem_addr_s   = RESET_PC;
                instr_s      = NOP;
                valid_s      = 1'b0;
                pa_s         = RESET_PC;
                skid_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state_r      <= S_IDLE;
            pc_r         <= RESET_PC;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= RESET_PC;
            instr_r      <= NOP;
            valid_r      <= 1'b0;
            pa_r         <= RESET_PC;
            skid_valid_r <= 1'b0;
            skid_data_r  <= 16'h0000;
            skid_addr_r  <= 16'h0000;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            mem_req_r    <= mem_req_s;
            mem_addr_r   <= mem_addr_s;
            instr_r      <= instr_s;
            valid_r      <= valid_s;
            pa_r         <= pa_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            skid_addr_r  <= skid_addr_s;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, all
// compared cycle by cycle against a queue-based fetch model.
module tb_instr_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOPW   = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        pc_src;
    logic [15:0] tgt;
    logic        stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] pc_address;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic [15:0] a;
    } ent_t;

    ent_t        q[$];
    logic        m_idle, m_flush, m_req;
    logic [15:0] m_pc, m_addr, m_pa;

    instr_fetch_unit #(.RESET_PC(RST_PC), .NOP(NOPW)) dut (
        .inp_clk(clk), .inp_rst_n(rst_n), .pcSrc(pc_src),
        .branchTarget_address(tgt), .stall(stall), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instruction(instruction), .instr_valid(instr_valid),
        .pc_address(pc_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_idle = 1'b1; m_flush = 1'b0; m_req = 1'b0;
        m_pc = RST_PC; m_addr = RST_PC; m_pa = RST_PC;
    endtask

    // Model: q holds fetched words in program order, q[0] is what is shown.
    task automatic model_step(input logic p, input logic [15:0] t, input logic s,
                              input logic a, input logic [15:0] rd);
        logic acked, consumed;
        acked    = m_req && a;
        consumed = (q.size() > 0) && !s;
        if (m_idle) begin
            m_idle = 1'b0; m_req = 1'b1; m_addr = m_pc;
        end else if (m_flush) begin
            if (p) m_pc = t;
            if (acked) begin m_flush = 1'b0; m_addr = m_pc; end
        end else if (p) begin
            q.delete();
            m_pc = t;
            if (m_req && !a) m_flush = 1'b1;
            else begin m_req = 1'b1; m_addr = t; end
        end else begin
            if (consumed) void'(q.pop_front());
            if (acked) begin
                q.push_back('{rd, m_addr});
                m_pc = m_addr + 16'd1;
            end
            if (!(m_req && !acked)) begin
                m_req  = (q.size() < 2);
                m_addr = m_pc;
            end
        end
        if (q.size() > 0) m_pa = q[0].a;
    endtask

    task automatic compare();
        chk("mem_req", {15'd0, mem_req}, {15'd0, m_req});
        if (m_req) chk("mem_addr", mem_addr, m_addr);
        chk("instr_valid", {15'd0, instr_valid}, {15'd0, (q.size() > 0)});
        chk("instruction", instruction, (q.size() > 0) ? q[0].d : NOPW);
        if (q.size() > 0) chk("pc_address", pc_address, m_pa);
    endtask

    // Called at a falling edge; applies inputs for one rising edge, then compares.
    task automatic cycle(input logic p, input logic [15:0] t, input logic s, input logic a);
        logic [15:0] rd;
        rd = 16'hA000 + m_addr;
        pc_src = p; tgt = t; stall = s; mem_ack = a; mem_rdata = rd;
        @(posedge clk);
        model_step(p, t, s, a, rd);
        @(negedge clk);
        compare();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   {15'd0, mem_req}, 16'd0);
        chk({tag, "_addr"},  mem_addr, RST_PC);
        chk({tag, "_instr"}, instruction, NOPW);
        chk({tag, "_valid"}, {15'd0, instr_valid}, 16'd0);
        chk({tag, "_pa"},    pc_address, RST_PC);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_values(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; pc_src = 1'b0; tgt = 16'h0000; stall = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        model_reset();
        #1 check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait streaming from reset, then a 3-cycle stall on A001.
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("first_addr", mem_addr, RST_PC);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("first_instr", instruction, 16'hA000);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("second_instr", instruction, 16'hA001);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("stall_hold", instruction, 16'hA001);
        chk("stall_noreq", {15'd0, mem_req}, 16'd0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("skid_out", instruction, 16'hA002);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("after_skid", instruction, 16'hA003);

        // Redirect with a 2-wait-state request to 0x0005 in flight.
        do_reset("rst2");
        n = 0;
        while (!(m_req && m_addr == 16'h0005) && n < 20) begin
            cycle(1'b0, 16'h0000, 1'b0, 1'b1);
            n++;
        end
        chk("reach_addr5", {15'd0, (n < 20)}, 16'd1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b1, 16'h0040, 1'b0, 1'b0);
        chk("flush_hold_addr", mem_addr, 16'h0005);
        chk("flush_invalid", {15'd0, instr_valid}, 16'd0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("flush_target", mem_addr, 16'h0040);
        chk("flush_drop", {15'd0, instr_valid}, 16'd0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("target_instr", instruction, 16'hA040);

        // Redirect coincident with ack.
        cycle(1'b1, 16'h0100, 1'b0, 1'b1);
        chk("coinc_addr", mem_addr, 16'h0100);
        chk("coinc_invalid", {15'd0, instr_valid}, 16'd0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("coinc_instr", instruction, 16'hA100);

        // Wrap of the program counter.
        cycle(1'b1, 16'hFFFF, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("wrap_pa_ffff", pc_address, 16'hFFFF);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("wrap_pa_0000", pc_address, 16'h0000);
        chk("wrap_instr", instruction, 16'hA000);

        // Asynchronous reset with a stalled, outstanding request.
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        stall = 1'b1;
        do_reset("rst_mid");
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("restart_req", {15'd0, mem_req}, 16'd1);
        chk("restart_addr", mem_addr, RST_PC);

        // Random traffic, including stray acks with no request pending.
        for (int i = 0; i < 3000; i++) begin
            logic p;
            p = (!m_idle) && ($urandom_range(0, 19) == 0);
            cycle(p, 16'($urandom), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
